// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared fetch-stage widths, reset PC, halt word and state encoding.
`default_nettype none

package instruction_fetch_unit_pkg;

  localparam int          ADDR_W    = 6;
  localparam int          INSTR_W   = 32;
  localparam int          RESET_PC  = 0;
  localparam logic [31:0] HALT_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with load, wrapping increment and hold.
`default_nettype none

module fetch_pc_reg #(
  parameter int              ADDR_W   = 6,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_pc,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  // Load has priority; increment wraps silently at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_load_pc;
    end else if (i_inc) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign o_pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: sequential fetch stage with valid/ready output, redirect and zero-word halt.
`default_nettype none

module instruction_fetch_unit #(
  parameter int ADDR_W       = instruction_fetch_unit_pkg::ADDR_W,
  parameter int INSTR_W      = instruction_fetch_unit_pkg::INSTR_W,
  parameter int RESET_PC     = instruction_fetch_unit_pkg::RESET_PC,
  parameter bit HALT_ON_ZERO = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  PCAdress,
  input  logic [INSTR_W-1:0] Instruction_in,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted
);

  import instruction_fetch_unit_pkg::*;

  localparam logic [ADDR_W-1:0]  c_RESET_PC  = ADDR_W'(RESET_PC);
  localparam logic [INSTR_W-1:0] c_HALT_WORD = INSTR_W'(HALT_WORD);

  fetch_state_e r_state, w_state_nxt;

  logic              w_pc_load;
  logic [ADDR_W-1:0] w_pc_load_val;
  logic              w_pc_inc;
  logic              w_capture;
  logic              w_clear_valid;
  logic              w_slot_free;
  logic              w_is_halt_word;
  logic [ADDR_W-1:0] w_pc;

  logic [INSTR_W-1:0] r_instr_out;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic               r_instr_valid;

  assign w_slot_free    = !r_instr_valid || instr_ready;
  assign w_is_halt_word = HALT_ON_ZERO && (Instruction_in == c_HALT_WORD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_load     = 1'b0;
    w_pc_load_val = redirect_pc;
    w_pc_inc      = 1'b0;
    w_capture     = 1'b0;
    w_clear_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pc_load = redirect;
        if (start) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // Redirect flushes the held word and drops the word on the bus this cycle.
        if (redirect) begin
          w_pc_load     = 1'b1;
          w_clear_valid = 1'b1;
        end else if (w_slot_free) begin
          if (w_is_halt_word) begin
            w_clear_valid = 1'b1;
            w_state_nxt   = ST_HALT;
          end else begin
            w_capture = 1'b1;
            w_pc_inc  = 1'b1;
          end
        end
      end
      ST_HALT: begin
        if (redirect) begin
          w_pc_load   = 1'b1;
          w_state_nxt = ST_FETCH;
        end else if (start) begin
          w_pc_load     = 1'b1;
          w_pc_load_val = c_RESET_PC;
          w_state_nxt   = ST_FETCH;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (c_RESET_PC)
  ) u_fetch_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_pc_load),
    .i_load_pc (w_pc_load_val),
    .i_inc     (w_pc_inc),
    .o_pc      (w_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr_out   <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
    end else if (w_capture) begin
      r_instr_out   <= Instruction_in;
      r_instr_pc    <= w_pc;
      r_instr_valid <= 1'b1;
    end else if (w_clear_valid) begin
      r_instr_valid <= 1'b0;
    end
  end

  assign PCAdress    = w_pc;
  assign instr_out   = r_instr_out;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign halted      = (r_state == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed vector table plus wrap/halt-restart sequences.
`default_nettype none

module tb_instruction_fetch_unit;

  localparam logic [31:0] W0 = 32'h0020_0005;
  localparam logic [31:0] W1 = 32'h00E0_0003;
  localparam logic [31:0] W2 = 32'h1064_0027;

  logic        clk = 1'b0;
  logic        rst_n, start, instr_ready, redirect;
  logic [5:0]  redirect_pc;

  logic [5:0]  addr_a, pc_a, addr_b, pc_b;
  logic [31:0] mem_a, out_a, mem_b, out_b;
  logic        valid_a, halted_a, valid_b, halted_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [5:0] a);
    case (a)
      6'd0:    return W0;
      6'd1:    return W1;
      6'd2:    return W2;
      default: return 32'h0;
    endcase
  endfunction

  assign mem_a = mem(addr_a);
  assign mem_b = mem(addr_b);

  instruction_fetch_unit #(.ADDR_W(6), .INSTR_W(32), .RESET_PC(0), .HALT_ON_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .PCAdress(addr_a), .Instruction_in(mem_a),
    .instr_out(out_a), .instr_pc(pc_a), .instr_valid(valid_a), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted_a)
  );

  instruction_fetch_unit #(.ADDR_W(6), .INSTR_W(32), .RESET_PC(0), .HALT_ON_ZERO(1'b0)) dut_nohalt (
    .clk(clk), .rst_n(rst_n), .start(start), .PCAdress(addr_b), .Instruction_in(mem_b),
    .instr_out(out_b), .instr_pc(pc_b), .instr_valid(valid_b), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted_b)
  );

  typedef struct {
    logic        rst_n, start, ready, redir;
    logic [5:0]  rpc;
    logic        ev;
    logic [31:0] eout;
    logic [5:0]  epc;
    logic        eh;
    logic [5:0]  eaddr;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic rdy, input logic rd, input logic [5:0] rp);
    rst_n = r; start = s; instr_ready = rdy; redirect = rd; redirect_pc = rp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //        rst  st  rdy red rpc    v   out  pc  h   addr
    vt[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b0, 6'd0};
    vt[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b0, 6'd0};
    vt[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1, W0,    6'd0, 1'b0, 6'd1};
    vt[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1, W1,    6'd1, 1'b0, 6'd2};
    vt[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1, W2,    6'd2, 1'b0, 6'd3};
    vt[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, W2,    6'd2, 1'b1, 6'd3};
    vt[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, W2,    6'd2, 1'b1, 6'd3};
    vt[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 6'd1, 1'b0, W2,    6'd2, 1'b0, 6'd1};
    vt[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1, W1,    6'd1, 1'b0, 6'd2};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, W1,    6'd1, 1'b0, 6'd2};
    vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, W1,    6'd1, 1'b0, 6'd2};
    vt[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, W1,    6'd1, 1'b0, 6'd2};
    vt[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1, W2,    6'd2, 1'b0, 6'd3};
    vt[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0, W2,    6'd2, 1'b0, 6'd0};
    vt[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1, W0,    6'd0, 1'b0, 6'd1};
    vt[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, W0,    6'd0, 1'b0, 6'd1};
    vt[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 1'b0, 32'h0, 6'd0, 1'b0, 6'd0};
    vt[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b0, 6'd0};

    drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
    for (int i = 0; i < 18; i++) begin
      drive(vt[i].rst_n, vt[i].start, vt[i].ready, vt[i].redir, vt[i].rpc);
      tick();
      chk($sformatf("v%0d.valid", i),  {31'b0, valid_a},  {31'b0, vt[i].ev});
      chk($sformatf("v%0d.out", i),    out_a,             vt[i].eout);
      chk($sformatf("v%0d.pc", i),     {26'b0, pc_a},     {26'b0, vt[i].epc});
      chk($sformatf("v%0d.halted", i), {31'b0, halted_a}, {31'b0, vt[i].eh});
      chk($sformatf("v%0d.addr", i),   {26'b0, addr_a},   {26'b0, vt[i].eaddr});
    end

    // Wrap at the top of the address space with halting disabled.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd0); tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 6'd0); tick();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 6'd62); tick();
    chk("wrap.redir_valid", {31'b0, valid_b}, 32'd0);
    chk("wrap.redir_addr",  {26'b0, addr_b},  32'd62);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 6'd0); tick();
    chk("wrap.62_valid", {31'b0, valid_b}, 32'd1);
    chk("wrap.62_pc",    {26'b0, pc_b},    32'd62);
    chk("wrap.62_out",   out_b,            32'h0);
    chk("halt62.halted", {31'b0, halted_a}, 32'd1);
    chk("halt62.addr",   {26'b0, addr_a},   32'd62);
    chk("halt62.valid",  {31'b0, valid_a},  32'd0);
    tick();
    chk("wrap.63_pc",     {26'b0, pc_b},     32'd63);
    chk("wrap.63_addr",   {26'b0, addr_b},   32'd0);
    chk("wrap.63_halted", {31'b0, halted_b}, 32'd0);
    tick();
    chk("wrap.0_pc",  {26'b0, pc_b},   32'd0);
    chk("wrap.0_out", out_b,           W0);
    chk("wrap.0_val", {31'b0, valid_b}, 32'd1);

    // Restart from HALT with start returns to the reset PC.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 6'd0); tick();
    chk("restart.halted", {31'b0, halted_a}, 32'd0);
    chk("restart.addr",   {26'b0, addr_a},   32'd0);
    chk("restart.valid",  {31'b0, valid_a},  32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 6'd0); tick();
    chk("restart.w0_out", out_a,            W0);
    chk("restart.w0_pc",  {26'b0, pc_a},    32'd0);
    chk("restart.w0_val", {31'b0, valid_a}, 32'd1);

    // Run into the halt again, then assert start and redirect together: redirect wins.
    tick(); tick(); tick();
    chk("rehalt.halted", {31'b0, halted_a}, 32'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 6'd2); tick();
    chk("both.addr",   {26'b0, addr_a},   32'd2);
    chk("both.halted", {31'b0, halted_a}, 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 6'd0); tick();
    chk("both.w2_out", out_a,         W2);
    chk("both.w2_pc",  {26'b0, pc_a}, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Sequential fetch stage on the read side of the instruction memory. Drives the 6-bit `PCAdress` into the combinational instruction memory and samples the returned 32-bit word. Registers the word with its PC toward decode over a valid/ready handshake. Handles stall, redirect (branch/jump from execute), and halt on the all-zero end-of-program word.

## Interface
Parameters:
- `ADDR_W`, 6: PC / instruction-memory address width.
- `INSTR_W`, 32: instruction width.
- `RESET_PC`, 0: PC value after reset and after `start` from HALT.
- `HALT_ON_ZERO`, 1: if 1, fetched word 0 ends the program; if 0, word 0 passes to decode as a normal word.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: begin fetching (level, sampled in IDLE/HALT).
- `PCAdress` out ADDR_W: address to instruction memory, equals PC register.
- `Instruction_in` in INSTR_W: memory data, valid combinationally in the same cycle as `PCAdress`.
- `instr_out` out INSTR_W: registered instruction to decode.
- `instr_pc` out ADDR_W: address `instr_out` was fetched from.
- `instr_valid` out 1: `instr_out` / `instr_pc` hold an unconsumed instruction.
- `instr_ready` in 1: decode accepts this cycle.
- `redirect` in 1: one-cycle pulse, flush and jump.
- `redirect_pc` in ADDR_W: jump target, sampled when `redirect`=1.
- `halted` out 1: FSM in HALT.

## Operation
- States: IDLE, FETCH, HALT. Reset values: state IDLE, PC=`RESET_PC`, `instr_out`=0, `instr_pc`=0, `instr_valid`=0, `halted`=0.
- IDLE: no capture.
  - `start`=1 → FETCH.
  - `redirect`=1 → PC←`redirect_pc`, stay IDLE.
- FETCH: a slot is free when `instr_valid`=0 or `instr_ready`=1. When free:
  - Capture `Instruction_in` → `instr_out`, PC → `instr_pc`, set `instr_valid`=1.
  - PC←(PC+1) mod 2^ADDR_W. 63 wraps to 0; wrap is silent.
- Not free (stall): PC, `instr_out`, `instr_pc`, `instr_valid` hold.
- Halt word, with `HALT_ON_ZERO`=1 and `Instruction_in`=0 in a free slot:
  - Not presented: `instr_valid`←0, PC holds at the zero-word address, go to HALT. `halted`=1 from the next cycle.
  - Any word accepted in the same cycle completes normally.
- HALT: no capture, `instr_valid`=0.
  - `start`=1 → PC←`RESET_PC`, `halted`←0, FETCH.
  - `redirect`=1 → PC←`redirect_pc`, `halted`←0, FETCH.
  - `redirect` wins if both are asserted.
- Redirect in FETCH has highest priority over capture and stall:
  - `instr_valid`←0, discarding the held word even if `instr_ready`=1 that cycle.
  - PC←`redirect_pc`; the word on `Instruction_in` that cycle is dropped.
  - Fetch resumes the next cycle from the target.
- `rst_n`=0 overrides everything in any state, including mid-stall and same-cycle redirect.

## Timing
- `PCAdress` is the PC register: no combinational path from any input.
- Start latency: `start` high in cycle N (IDLE) → `PCAdress`=`RESET_PC` in N+1 → `instr_valid`=1 with word 0 in N+2.
- Throughput: one instruction per cycle while `instr_ready`=1.
- Stall: deasserting `instr_ready` freezes outputs the same cycle; no word is lost or duplicated.
- Redirect: `redirect` in cycle N → `instr_valid`=0 in N+1, `PCAdress`=target in N+1, target word valid in N+2.
- Halt: zero word at `PCAdress` in cycle N (slot free) → `halted`=1 and `instr_valid`=0 in N+1.

## Structure
- Shared package: `ADDR_W`, `INSTR_W`, `RESET_PC`, `HALT_WORD` (32'h0), fetch-state encoding (IDLE/FETCH/HALT) for reuse by decode/debug.
- One natural sub-module, `fetch_pc_reg`: PC register with load (redirect/start), increment-with-wrap, and hold. The FSM and output register stay in the top.

## Test plan
Program image {0:0x00200005, 1:0x00E00003, 2:0x10640027, others 0}, memory modelled combinationally in the bench.
- Reset then `start` pulse, `instr_ready`=1 → (0,0x00200005), (1,0x00E00003), (2,0x10640027) on consecutive cycles; then `halted`=1, `instr_valid`=0, `PCAdress`=3.
- `instr_ready`=0 for 3 cycles while word at PC 1 is presented → `instr_out`=0x00E00003 / `instr_pc`=1 held, PC=2 held; then resumes with no loss or duplication.
- `redirect`=1, `redirect_pc`=0 while (2,0x10640027) is valid and `instr_ready`=1 → word flushed, next valid is (0,0x00200005) two cycles later.
- `HALT_ON_ZERO`=0, redirect to 62 → (62,0), (63,0), (0,0x00200005): PC wraps, no halt.
- In HALT, `redirect_pc`=1 → `halted` clears, sequence restarts at (1,0x00E00003).
- `rst_n`=0 for one cycle mid-stream while stalled → all outputs return to reset values, state IDLE, `PCAdress`=0.
